// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the PWM update scheduler: field codes,
// default data width, per-channel state encoding and bus-slice helpers.
package pwm_cfg_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int CH_MAX     = 16;

  localparam logic [1:0] FLD_PRESCALER = 2'd0;
  localparam logic [1:0] FLD_COUNT     = 2'd1;
  localparam logic [1:0] FLD_SWITCH    = 2'd2;
  localparam logic [1:0] FLD_ENABLE    = 2'd3;

  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_PENDING = 1'b1
  } ch_state_t;

  // Channel ch occupies bits [ch_lo(ch, dw) +: dw] of a packed output bus.
  function automatic int ch_lo(input int ch, input int dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/pwm_channel_shadow.sv
// One timer channel: shadow and active copies of its configuration, the
// pending/idle state and the restart flag that drives the timer reset.
module pwm_channel_shadow
  import pwm_cfg_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          _RST,
  input  logic          wr_en,
  input  logic [1:0]    wr_field,
  input  logic [DW-1:0] wr_data,
  input  logic          commit,
  input  logic          force_apply,
  input  logic          period_end,
  output logic [DW-1:0] prescaler,
  output logic [DW-1:0] count,
  output logic [DW-1:0] switch_val,
  output logic          enable,
  output logic          rst_n,
  output ch_state_t     state
);

  logic [DW-1:0] sh_psc_q, sh_psc_d, sh_cnt_q, sh_cnt_d, sh_sw_q, sh_sw_d;
  logic          sh_en_q, sh_en_d;
  logic [DW-1:0] act_psc_q, act_psc_d, act_cnt_q, act_cnt_d, act_sw_q, act_sw_d;
  logic          act_en_q, act_en_d;
  logic          restart_q, restart_d;
  logic          rst_n_q, rst_n_d;
  ch_state_t     state_q, state_d;
  logic          apply;

  always_comb begin
    sh_psc_d = sh_psc_q;
    sh_cnt_d = sh_cnt_q;
    sh_sw_d  = sh_sw_q;
    sh_en_d  = sh_en_q;
    if (wr_en) begin
      case (wr_field)
        FLD_PRESCALER: sh_psc_d = wr_data;
        FLD_COUNT:     sh_cnt_d = wr_data;
        FLD_SWITCH:    sh_sw_d  = wr_data;
        default:       sh_en_d  = wr_data[0];
      endcase
    end

    // A disabled timer is idle, so a pending commit needs no boundary.
    apply = force_apply ||
            ((state_q == CH_PENDING) && (!act_en_q || period_end));

    // Apply takes the next shadow so a same-cycle write is not lost.
    act_psc_d = apply ? sh_psc_d : act_psc_q;
    act_cnt_d = apply ? sh_cnt_d : act_cnt_q;
    act_sw_d  = apply ? sh_sw_d  : act_sw_q;
    act_en_d  = apply ? sh_en_d  : act_en_q;

    state_d = state_q;
    if (force_apply) begin
      state_d = CH_IDLE;
    end else if (state_q == CH_PENDING) begin
      if (apply) state_d = CH_IDLE;
    end else if (commit) begin
      state_d = CH_PENDING;
    end

    restart_d = force_apply;
    rst_n_d   = act_en_d && !restart_d;
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      sh_psc_q  <= '0;
      sh_cnt_q  <= '0;
      sh_sw_q   <= '0;
      sh_en_q   <= 1'b0;
      act_psc_q <= '0;
      act_cnt_q <= '0;
      act_sw_q  <= '0;
      act_en_q  <= 1'b0;
      restart_q <= 1'b0;
      rst_n_q   <= 1'b0;
      state_q   <= CH_IDLE;
    end else begin
      sh_psc_q  <= sh_psc_d;
      sh_cnt_q  <= sh_cnt_d;
      sh_sw_q   <= sh_sw_d;
      sh_en_q   <= sh_en_d;
      act_psc_q <= act_psc_d;
      act_cnt_q <= act_cnt_d;
      act_sw_q  <= act_sw_d;
      act_en_q  <= act_en_d;
      restart_q <= restart_d;
      rst_n_q   <= rst_n_d;
      state_q   <= state_d;
    end
  end

  assign prescaler  = act_psc_q;
  assign count      = act_cnt_q;
  assign switch_val = act_sw_q;
  assign enable     = act_en_q;
  assign rst_n      = rst_n_q;
  assign state      = state_q;

  logic unused_restart;
  assign unused_restart = restart_q;

endmodule

// File: rtl/pwm_update_scheduler.sv
// Host-facing PWM configuration scheduler: decodes shadow writes, fans out
// commits, and moves shadow to active per channel at period boundaries.
module pwm_update_scheduler
  import pwm_cfg_pkg::*;
#(
  parameter int  CHANNELS = 8,
  parameter int  DW       = DW_DEFAULT,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   CLK,
  input  logic                   _RST,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [CW-1:0]          wr_chan,
  input  logic [1:0]             wr_field,
  input  logic [DW-1:0]          wr_data,
  input  logic                   commit_valid,
  input  logic [CHANNELS-1:0]    commit_mask,
  input  logic                   commit_force,
  input  logic [CHANNELS-1:0]    period_end,
  output logic [DW*CHANNELS-1:0] prescaler_out,
  output logic [DW*CHANNELS-1:0] count_out,
  output logic [DW*CHANNELS-1:0] switch_out,
  output logic [CHANNELS-1:0]    ch_enable,
  output logic [CHANNELS-1:0]    ch_rst_n,
  output logic [CHANNELS-1:0]    pending
);

  // Handshake: a write transfers on a rising CLK edge where wr_valid && wr_ready;
  // wr_ready drops only while the addressed channel has an unapplied commit,
  // and an out-of-range channel is always ready and its data is dropped.
  ch_state_t ch_state [CHANNELS];

  always_comb begin
    wr_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_chan == CW'(i)) wr_ready = !pending[i];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr_en_i, commit_i, force_i;

    assign wr_en_i  = wr_valid && wr_ready && (wr_chan == CW'(i));
    assign commit_i = commit_valid && !commit_force && commit_mask[i];
    assign force_i  = commit_valid && commit_force && commit_mask[i];
    assign pending[i] = (ch_state[i] == CH_PENDING);

    pwm_channel_shadow #(.DW(DW)) u_ch (
      .CLK         (CLK),
      ._RST        (_RST),
      .wr_en       (wr_en_i),
      .wr_field    (wr_field),
      .wr_data     (wr_data),
      .commit      (commit_i),
      .force_apply (force_i),
      .period_end  (period_end[i]),
      .prescaler   (prescaler_out[ch_lo(i, DW) +: DW]),
      .count       (count_out[ch_lo(i, DW) +: DW]),
      .switch_val  (switch_out[ch_lo(i, DW) +: DW]),
      .enable      (ch_enable[i]),
      .rst_n       (ch_rst_n[i]),
      .state       (ch_state[i])
    );
  end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed bench for pwm_update_scheduler: shadow writes, commits at period
// boundaries, write stalls, forced applies, commit/period_end overlap, reset.
module tb_pwm_update_scheduler;
  import pwm_cfg_pkg::*;

  localparam int CHANNELS = 8;
  localparam int DW       = 16;
  localparam int CW       = 3;

  logic                   CLK;
  logic                   _RST;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [CW-1:0]          wr_chan;
  logic [1:0]             wr_field;
  logic [DW-1:0]          wr_data;
  logic                   commit_valid;
  logic [CHANNELS-1:0]    commit_mask;
  logic                   commit_force;
  logic [CHANNELS-1:0]    period_end;
  logic [DW*CHANNELS-1:0] prescaler_out;
  logic [DW*CHANNELS-1:0] count_out;
  logic [DW*CHANNELS-1:0] switch_out;
  logic [CHANNELS-1:0]    ch_enable;
  logic [CHANNELS-1:0]    ch_rst_n;
  logic [CHANNELS-1:0]    pending;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  pwm_update_scheduler #(.CHANNELS(CHANNELS), .DW(DW)) dut (
    .CLK           (CLK),
    ._RST          (_RST),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_chan       (wr_chan),
    .wr_field      (wr_field),
    .wr_data       (wr_data),
    .commit_valid  (commit_valid),
    .commit_mask   (commit_mask),
    .commit_force  (commit_force),
    .period_end    (period_end),
    .prescaler_out (prescaler_out),
    .count_out     (count_out),
    .switch_out    (switch_out),
    .ch_enable     (ch_enable),
    .ch_rst_n      (ch_rst_n),
    .pending       (pending)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] sl(input logic [DW*CHANNELS-1:0] bus, input int ch);
    return bus[ch*DW +: DW];
  endfunction

  task automatic host_write(input int ch, input logic [1:0] fld, input logic [DW-1:0] data);
    int n;
    wr_valid = 1'b1;
    wr_chan  = CW'(ch);
    wr_field = fld;
    wr_data  = data;
    n = 0;
    while (!wr_ready && n < 50) begin
      step();
      n++;
    end
    if (!wr_ready) check("wr_ready_timeout", wr_ready, 1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic commit(input logic [CHANNELS-1:0] mask, input logic frc);
    commit_valid = 1'b1;
    commit_mask  = mask;
    commit_force = frc;
  endtask

  task automatic commit_clear();
    commit_valid = 1'b0;
    commit_mask  = '0;
    commit_force = 1'b0;
  endtask

  task automatic check_sw0(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(tag, sl(switch_out, 0), e);
    end
  endtask

  initial begin
    _RST = 1'b0;
    wr_valid = 1'b0; wr_chan = '0; wr_field = '0; wr_data = '0;
    commit_valid = 1'b0; commit_mask = '0; commit_force = 1'b0;
    period_end = '0;
    #22;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_enable", ch_enable, 0);
    check("rst_pending", pending, 0);
    check("rst_rst_n", ch_rst_n, 0);
    check("rst_count", count_out, 0);
    _RST = 1'b1;
    step();

    // Disabled channel: commit applies two edges later
    host_write(0, FLD_PRESCALER, 16'd3);
    host_write(0, FLD_COUNT, 16'd9);
    host_write(0, FLD_SWITCH, 16'd4);
    host_write(0, FLD_ENABLE, 16'd1);
    check("shadow_only_count", sl(count_out, 0), 0);
    commit(8'h01, 1'b0);
    step();
    commit_clear();
    check("t1_pending_set", pending, 8'h01);
    check("t1_not_yet_enabled", ch_enable[0], 0);
    step();
    exp_q.push_back(16'd4);
    check("t1_enable", ch_enable[0], 1);
    check("t1_count", sl(count_out, 0), 9);
    check("t1_prescaler", sl(prescaler_out, 0), 3);
    check_sw0("t1_switch");
    check("t1_rst_n", ch_rst_n[0], 1);
    check("t1_pending_clr", pending, 0);

    // Enabled channel waits for period_end
    host_write(0, FLD_SWITCH, 16'd7);
    commit(8'h01, 1'b0);
    step();
    commit_clear();
    for (int k = 0; k < 3; k++) begin
      check("t2_switch_hold", sl(switch_out, 0), 4);
      check("t2_pending_hold", pending[0], 1);
      step();
    end
    period_end = 8'h01;
    step();
    period_end = '0;
    exp_q.push_back(16'd7);
    check_sw0("t2_switch_new");
    check("t2_pending_clr", pending[0], 0);

    // Write to a pending channel stalls until the apply edge
    host_write(0, FLD_COUNT, 16'd20);
    commit(8'h01, 1'b0);
    step();
    commit_clear();
    wr_valid = 1'b1; wr_chan = 3'd0; wr_field = FLD_COUNT; wr_data = 16'd55;
    check("t3_stall0", wr_ready, 0);
    step();
    check("t3_stall1", wr_ready, 0);
    period_end = 8'h01;
    step();
    period_end = '0;
    check("t3_ready_after_apply", wr_ready, 1);
    check("t3_count_applied", sl(count_out, 0), 20);
    step();
    wr_valid = 1'b0;
    step();
    check("t3_held_write_shadow_only", sl(count_out, 0), 20);

    // Forced commit of ch0 and ch1 mid-period
    host_write(1, FLD_COUNT, 16'd5);
    host_write(1, FLD_ENABLE, 16'd1);
    host_write(0, FLD_SWITCH, 16'd9);
    commit(8'h03, 1'b1);
    step();
    commit_clear();
    exp_q.push_back(16'd9);
    check("t4_count1", sl(count_out, 1), 5);
    check("t4_count0", sl(count_out, 0), 55);
    check_sw0("t4_switch0");
    check("t4_enable", ch_enable[1:0], 2'b11);
    check("t4_rst_pulse", ch_rst_n[1:0], 2'b00);
    check("t4_pending", pending, 0);
    step();
    check("t4_rst_release", ch_rst_n[1:0], 2'b11);

    // Commit coincident with period_end on an idle enabled channel
    host_write(2, FLD_ENABLE, 16'd1);
    commit(8'h04, 1'b0);
    step();
    commit_clear();
    step();
    check("t5_enabled", ch_enable[2], 1);
    host_write(2, FLD_SWITCH, 16'd6);
    commit(8'h04, 1'b0);
    period_end = 8'h04;
    step();
    commit_clear();
    period_end = '0;
    check("t5_pending_set", pending[2], 1);
    check("t5_no_apply", sl(switch_out, 2), 0);
    step();
    check("t5_still_waiting", sl(switch_out, 2), 0);
    period_end = 8'h04;
    step();
    period_end = '0;
    check("t5_applied", sl(switch_out, 2), 6);
    check("t5_pending_clr", pending[2], 0);

    // Reset while four channels are pending
    host_write(3, FLD_COUNT, 16'd13);
    commit(8'h0F, 1'b0);
    step();
    commit_clear();
    check("t6_pending_0f", pending, 8'h0F);
    _RST = 1'b0;
    #1;
    check("t6_rst_pending", pending, 0);
    check("t6_rst_enable", ch_enable, 0);
    check("t6_rst_rst_n", ch_rst_n, 0);
    check("t6_rst_count", count_out, 0);
    check("t6_rst_switch", switch_out, 0);
    check("t6_rst_ready", wr_ready, 1);
    step();
    #2;
    _RST = 1'b1;
    period_end = 8'hFF;
    step();
    period_end = '0;
    step();
    check("t6_no_apply_pending", pending, 0);
    check("t6_no_apply_enable", ch_enable, 0);
    check("t6_no_apply_count", count_out, 0);
    check("t6_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1);
  end

endmodule

// File: doc/pwm_update_scheduler.md
# pwm_update_scheduler

Configuration controller for a bank of PWM timer channels. Hosts write new Prescaler, Count and SwitchValue values into per-channel shadow registers. They then issue a commit. The scheduler moves shadow values into the active registers that drive each timer only at that channel's period boundary, so no period is torn. It sits between the host register interface (I2C/SPI slave) and the timer array, and owns each timer's active-low reset.

## Interface
- CHANNELS, 8: number of timer channels (1–16)
- DW, 16: width of Prescaler/Count/SwitchValue
- CLK  in  1  system clock, rising edge
- _RST  in  1  reset, asynchronous, active-low
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_chan  in  $clog2(CHANNELS)  target channel
- wr_field  in  2  0=Prescaler, 1=Count, 2=SwitchValue, 3=Enable
- wr_data  in  DW  write value; Enable uses wr_data[0]
- commit_valid  in  1  commit request (always accepted)
- commit_mask  in  CHANNELS  channels to commit
- commit_force  in  1  apply next edge, ignore period boundary, restart timers
- period_end  in  CHANNELS  1-cycle pulse from each timer on counter wrap
- prescaler_out / count_out / switch_out  out  DW*CHANNELS  active values, channel i at [i*DW +: DW]
- ch_enable  out  CHANNELS  active enable
- ch_rst_n  out  CHANNELS  per-timer active-low reset
- pending  out  CHANNELS  commit requested, not yet applied

## Operation
- Reset values:
  - all shadow and active registers 0
  - ch_enable, pending and ch_rst_n all 0
  - wr_ready 1
- Write:
  - wr_ready = !pending[wr_chan], combinational.
  - Writes to a pending channel stall until the apply completes.
  - An accepted write updates one shadow field. Active registers are untouched.
  - wr_chan >= CHANNELS is accepted and discarded.
- Commit without force:
  - pending |= commit_mask. Bits already pending stay set (no-op).
- Apply (channel i, pending[i]=1):
  - If ch_enable[i]=1, apply on the edge where period_end[i]=1.
  - If ch_enable[i]=0, apply on the next edge (the timer is idle).
  - Apply copies all four shadow fields to active and clears pending[i].
- Commit with force:
  - Every mask channel applies on the next edge, regardless of period_end or pending.
  - Each of those channels gets a restart pulse.
- ch_rst_n[i] = ch_enable[i] && !restart[i]. A disabled timer is held in reset.
- restart[i] is high exactly one cycle, the cycle after a forced apply.
- Per-channel state: IDLE → (commit) PENDING → (period_end or !enable) IDLE. Force takes IDLE or PENDING → IDLE in one edge.
- Simultaneous events:
  - Commit and period_end[i] in the same cycle, channel not already pending: pending is set; apply waits for the next period_end.
  - Channel already pending: that period_end applies it, and the new commit bit is a no-op.
  - Write and commit to the same non-pending channel in the same cycle: the write lands in shadow before the apply.
  - Force and period_end together: force wins, single apply.
- Reset mid-operation clears pending and discards commits in flight. Shadow contents are lost.

## Timing
- Write-to-shadow: 1 edge.
- Commit to a disabled channel: active values visible 2 cycles after commit_valid (1 edge to set pending, 1 to apply).
- Enabled channel: new values visible the cycle after the period_end pulse that is sampled while pending.
- Forced apply: new values and ch_rst_n=0 are both visible the cycle after commit_valid. ch_rst_n returns to 1 one cycle later.
- No combinational path from period_end to any output. All outputs are registered except wr_ready.

## Structure
- Package pwm_cfg_pkg:
  - field codes FLD_PRESCALER/FLD_COUNT/FLD_SWITCH/FLD_ENABLE
  - DW default
  - channel-slice helper constants
- Sub-module pwm_channel_shadow holds one channel's shadow, active, pending flag and restart flag. The top instantiates CHANNELS copies via generate and handles write decode and wr_ready.

## Test plan
- Disabled channel: write ch0 Prescaler=3, Count=9, Switch=4, Enable=1; commit mask 0x01 → 2 cycles later ch_enable[0]=1, count_out ch0=9, ch_rst_n[0]=1, pending=0.
- Enabled ch0: write Switch=7, commit → switch_out stays 4 until period_end[0] pulses; 7 appears the following cycle; pending[0] is high throughout the wait.
- Write to pending ch0 → wr_ready=0 until the apply edge. The held write then lands in shadow only and does not change the active value.
- Force commit mask 0x03 mid-period → both channels update next cycle; ch_rst_n[1:0]=00 for exactly one cycle, then 11.
- Commit with period_end[2] in the same cycle (ch2 enabled, not pending) → no apply that cycle; apply occurs on the next period_end[2].
- Assert _RST low while pending=0x0F → all outputs return to reset values immediately; no apply after release.
